// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
// The FSM encoding is fixed so that state values stay stable in waveforms.
package cpu_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Fetch-side bus of the sequencer: instruction-memory req/ack plus the IR-to-decode
// valid/ready pair.
interface pc_fetch_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, inst, inst_valid,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_valid,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/pc_fetch_seq_dffe32.sv
// 32-bit enabled D flip-flop with asynchronous active-low clear to a parameterised value.
module dffe32 #(
  parameter logic [31:0] ResetVal = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Program counter and fetch sequencer: holds the PC, fetches via req/ack and hands the
// instruction register to decode via valid/ready.
module pc_fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               clrn,
  pc_fetch_seq_if.master     bus,
  input  logic [31:0]        npc,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  output logic               misalign,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q;
  logic               req_q;
  logic               discard_q;
  logic               inst_valid_q;
  logic               misalign_q;
  logic [CNT_W-1:0]   retired_q;
  logic [31:0]        pc_q;
  logic [31:0]        ir_q;

  logic               accept;
  logic               retire;
  logic               pc_load;
  logic [31:0]        target;
  logic               ir_en;

  // An ack only counts while our own request is up, so stale acks after reset are ignored.
  assign accept  = req_q & bus.imem_ack;
  assign retire  = (state_q == ST_HOLD) & bus.id_ready & ~flush;
  assign pc_load = flush | retire;
  assign target  = flush ? flush_pc : npc;
  assign ir_en   = accept & ~discard_q & ~flush;

  dffe32 #(
    .ResetVal (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .clrn (clrn),
    .en   (pc_load),
    .d    ({target[31:2], 2'b00}),
    .q    (pc_q)
  );

  dffe32 #(
    .ResetVal (32'h0000_0000)
  ) u_ir_reg (
    .clk  (clk),
    .clrn (clrn),
    .en   (ir_en),
    .d    (bus.imem_rdata),
    .q    (ir_q)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_FETCH;
      req_q        <= 1'b0;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      retired_q    <= '0;
    end else begin
      misalign_q <= pc_load & (target[1:0] != 2'b00);
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (flush) begin
        // A request still in flight must complete; its data is dropped via discard.
        state_q      <= ST_FETCH;
        inst_valid_q <= 1'b0;
        req_q        <= 1'b1;
        discard_q    <= req_q & ~bus.imem_ack;
      end else begin
        unique case (state_q)
          ST_FETCH: begin
            if (!req_q) begin
              req_q <= 1'b1;
            end else if (accept) begin
              req_q <= 1'b0;
              if (discard_q) begin
                discard_q <= 1'b0;
              end else begin
                inst_valid_q <= 1'b1;
                state_q      <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (bus.id_ready) begin
              inst_valid_q <= 1'b0;
              req_q        <= 1'b1;
              state_q      <= ST_FETCH;
            end
          end
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = ir_q;
  assign bus.inst_valid = inst_valid_q;
  assign pc             = pc_q;
  assign pc4            = pc_q + PC_INC;
  assign misalign       = misalign_q;
  assign retired        = retired_q;

endmodule
